// File: rtl/clk_div_bank.sv
// Multi-channel clock divider bank with handshake-loaded, boundary-aligned divide ratios.
// Optional macro SYNC_RESTART_EN adds a `restart` input that phase-aligns all channels.
module clk_div_bank #(
  parameter int CHANNELS    = 2,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 0,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                div_valid,
  output logic                div_ready,
  input  logic [CH_W-1:0]     div_chan,
  input  logic [CNT_W-1:0]    div_value,
`ifdef SYNC_RESTART_EN
  input  logic                restart,
`endif
  output logic [CHANNELS-1:0] out,
  output logic                busy
);

  typedef enum logic {ST_IDLE, ST_PEND} state_e;

  localparam logic [CH_W:0]    CH_LIMIT = (CH_W+1)'(CHANNELS);
  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     chan_q, chan_d;
  logic [CNT_W-1:0]    value_q, value_d;
  logic [CHANNELS-1:0] bnd;
  logic [CHANNELS-1:0] apply_vec;
  logic                chan_ok;
  logic                restart_w;

`ifdef SYNC_RESTART_EN
  assign restart_w = restart;
`else
  assign restart_w = 1'b0;
`endif

  assign chan_ok   = ({1'b0, chan_q} < CH_LIMIT);
  assign div_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_PEND);

  // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    value_d   = value_q;
    apply_vec = '0;
    case (state_q)
      ST_IDLE: begin
        if (div_valid) begin
          state_d = ST_PEND;
          chan_d  = div_chan;
          value_d = div_value;
        end
      end
      ST_PEND: begin
        if (!chan_ok) begin
          state_d = ST_IDLE;
        end else if (!restart_w) begin
          // A restart edge defers the apply to the next boundary seen afterwards.
          for (int i = 0; i < CHANNELS; i++) begin
            if (chan_q == CH_W'(i) && bnd[i]) begin
              apply_vec[i] = 1'b1;
              state_d      = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      chan_q  <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      value_q <= value_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             out_q, out_d;
    logic             at_wrap;

    assign at_wrap = (cnt_q == div_q);
    // Safe apply point: end of a half-period, or a channel that is not counting.
    assign bnd[g]  = !en[g] || at_wrap;
    assign out[g]  = out_q;

    always_comb begin
      cnt_d = cnt_q;
      div_d = div_q;
      out_d = out_q;
      if (apply_vec[g]) div_d = value_q;
      if (restart_w) begin
        cnt_d = '0;
        out_d = 1'b0;
      end else begin
        if (en[g]) begin
          if (at_wrap) begin
            cnt_d = '0;
            out_d = ~out_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (apply_vec[g]) cnt_d = '0;
      end
    end

    // NOTE: the divide registers are reset too, so a cleared block always runs at DEFAULT_DIV.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        div_q <= DIV_RST;
        out_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        div_q <= div_d;
        out_q <= out_d;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: a 2-channel instance for the main scenarios and a
// 3-channel instance whose 2-bit channel index can address a non-existent channel.
module tb_clk_div_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] en;
  logic       div_valid;
  logic       div_ready;
  logic [0:0] div_chan;
  logic [7:0] div_value;
  logic [1:0] out;
  logic       busy;
  logic       restart;

  logic [2:0] en3;
  logic       valid3;
  logic       ready3;
  logic [1:0] chan3;
  logic [7:0] value3;
  logic [2:0] out3;
  logic       busy3;
  logic       restart3;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  clk_div_bank #(.CHANNELS(2), .CNT_W(8), .DEFAULT_DIV(0)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .div_chan  (div_chan),
    .div_value (div_value),
`ifdef SYNC_RESTART_EN
    .restart   (restart),
`endif
    .out       (out),
    .busy      (busy)
  );

  clk_div_bank #(.CHANNELS(3), .CNT_W(8), .DEFAULT_DIV(0)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en3),
    .div_valid (valid3),
    .div_ready (ready3),
    .div_chan  (chan3),
    .div_value (value3),
`ifdef SYNC_RESTART_EN
    .restart   (restart3),
`endif
    .out       (out3),
    .busy      (busy3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = '0; div_valid = 1'b0; div_chan = '0; div_value = '0; restart = 1'b0;
    en3 = '0; valid3 = 1'b0; chan3 = '0; value3 = '0; restart3 = 1'b0;
    #12;
    total_cnt++; if (out !== 2'b00) $display("FAIL reset_out: got %b want 00", out); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (div_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", div_ready); else pass_cnt++;
    total_cnt++; if (out3 !== 3'b000) $display("FAIL reset_out3: got %b want 000", out3); else pass_cnt++;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_divide0();
    logic [1:0] exp;
    en = 2'b11;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp = (k % 2 == 1) ? 2'b11 : 2'b00;
      total_cnt++;
      if (out !== exp) $display("FAIL div0_edge%0d: got %b want %b", k, out, exp); else pass_cnt++;
    end
  endtask

  task automatic test_load_running();
    logic [1:0] exp;
    div_valid = 1'b1; div_chan = 1'b1; div_value = 8'd3;
    total_cnt++; if (div_ready !== 1'b1) $display("FAIL run_ready_pre: got %b want 1", div_ready); else pass_cnt++;
    tick();
    div_valid = 1'b0;
    total_cnt++; if (busy !== 1'b1) $display("FAIL run_busy_accept: got %b want 1", busy); else pass_cnt++;
    total_cnt++; if (div_ready !== 1'b0) $display("FAIL run_ready_accept: got %b want 0", div_ready); else pass_cnt++;
    total_cnt++; if (out !== 2'b11) $display("FAIL run_out_accept: got %b want 11", out); else pass_cnt++;
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL run_busy_apply: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (out !== 2'b00) $display("FAIL run_out_apply: got %b want 00", out); else pass_cnt++;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp[0] = (k % 2 == 1);
      exp[1] = (k >= 4 && k < 8);
      total_cnt++;
      if (out !== exp) $display("FAIL run_div3_edge%0d: got %b want %b", k, out, exp); else pass_cnt++;
    end
  endtask

  task automatic test_load_disabled();
    en = 2'b10;
    div_valid = 1'b1; div_chan = 1'b0; div_value = 8'd5;
    tick();
    div_valid = 1'b0;
    total_cnt++; if (busy !== 1'b1) $display("FAIL dis_busy_accept: got %b want 1", busy); else pass_cnt++;
    total_cnt++; if (out[0] !== 1'b0) $display("FAIL dis_out_hold: got %b want 0", out[0]); else pass_cnt++;
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL dis_busy_apply: got %b want 0", busy); else pass_cnt++;
    en = 2'b11;
    for (int k = 1; k <= 7; k++) begin
      tick();
      total_cnt++;
      if (out[0] !== (k >= 6)) $display("FAIL dis_div5_edge%0d: got %b want %b", k, out[0], (k >= 6)); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp;
    valid3 = 1'b1; chan3 = 2'd3; value3 = 8'd7;
    total_cnt++; if (ready3 !== 1'b1) $display("FAIL bad_ready_pre: got %b want 1", ready3); else pass_cnt++;
    tick();
    total_cnt++; if (busy3 !== 1'b1) $display("FAIL bad_busy_accept: got %b want 1", busy3); else pass_cnt++;
    total_cnt++; if (ready3 !== 1'b0) $display("FAIL bad_ready_accept: got %b want 0", ready3); else pass_cnt++;
    chan3 = 2'd0; value3 = 8'd1;
    tick();
    total_cnt++; if (busy3 !== 1'b0) $display("FAIL bad_busy_drop: got %b want 0", busy3); else pass_cnt++;
    total_cnt++; if (ready3 !== 1'b1) $display("FAIL bad_ready_back: got %b want 1", ready3); else pass_cnt++;
    tick();
    valid3 = 1'b0;
    total_cnt++; if (busy3 !== 1'b1) $display("FAIL b2b_busy_second: got %b want 1", busy3); else pass_cnt++;
    tick();
    total_cnt++; if (busy3 !== 1'b0) $display("FAIL b2b_busy_apply: got %b want 0", busy3); else pass_cnt++;
    en3 = 3'b111;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp[0] = (k == 2 || k == 3);
      exp[1] = (k % 2 == 1);
      exp[2] = (k % 2 == 1);
      total_cnt++;
      if (out3 !== exp) $display("FAIL b2b_out3_edge%0d: got %b want %b", k, out3, exp); else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] exp;
    en = 2'b11;
    div_valid = 1'b1; div_chan = 1'b0; div_value = 8'd7;
    tick();
    div_valid = 1'b0;
    total_cnt++; if (busy !== 1'b1) $display("FAIL arst_busy_pend: got %b want 1", busy); else pass_cnt++;
    #3;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (out !== 2'b00) $display("FAIL arst_out: got %b want 00", out); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (div_ready !== 1'b1) $display("FAIL arst_ready: got %b want 1", div_ready); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    en3 = '0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp = (k % 2 == 1) ? 2'b11 : 2'b00;
      total_cnt++;
      if (out !== exp) $display("FAIL arst_default_edge%0d: got %b want %b", k, out, exp); else pass_cnt++;
    end
  endtask

`ifdef SYNC_RESTART_EN
  task automatic test_restart();
    logic [1:0] exp;
    en = 2'b00;
    div_valid = 1'b1; div_chan = 1'b0; div_value = 8'd2;
    tick();
    div_valid = 1'b0;
    tick();
    div_valid = 1'b1; div_chan = 1'b1; div_value = 8'd4;
    tick();
    div_valid = 1'b0;
    tick();
    en = 2'b11;
    for (int k = 0; k < 7; k++) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    total_cnt++; if (out !== 2'b00) $display("FAIL rst_sync_out: got %b want 00", out); else pass_cnt++;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp[0] = (k >= 3);
      exp[1] = (k >= 5);
      total_cnt++;
      if (out !== exp) $display("FAIL restart_edge%0d: got %b want %b", k, out, exp); else pass_cnt++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_divide0();
    test_load_running();
    test_load_disabled();
    test_back_to_back();
    test_async_reset();
`ifdef SYNC_RESTART_EN
    test_restart();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
